// File: rtl/pipe_scroller.sv
// Scrolling pipe-column generator: a free-running refresh divider, an LFSR gap source and an IDLE/RUN/HALT control FSM.
// Optional pass counter enabled by defining PIPE_PASS_CNT_EN.
module pipe_scroller #(
  parameter int unsigned NUM_PIPES = 2,
  parameter int unsigned PIPE_W    = 41,
  parameter int unsigned MIN_X     = 57,
  parameter int unsigned MAX_X     = 320,
  parameter int unsigned MIN_Y     = 45,
  parameter int unsigned INIT_X    = 150,
  parameter int unsigned SPACING   = 132,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned TICK_DIV  = 19,
  parameter int unsigned GAP_BASE  = 100,
  parameter int unsigned GAP_SPAN  = 200,
  parameter int unsigned INIT_GAP  = 205
`ifdef PIPE_PASS_CNT_EN
  ,
  parameter int unsigned BIRD_X    = 100
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      collide,
  output logic [10*NUM_PIPES-1:0]   pipe_l,
  output logic [10*NUM_PIPES-1:0]   pipe_r,
  output logic [10*NUM_PIPES-1:0]   pipe_gap_t,
  output logic                      running,
  output logic                      refr_tick
`ifdef PIPE_PASS_CNT_EN
  ,
  output logic [7:0]                pass_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]          state;
  logic [TICK_DIV-1:0] div;
  logic [15:0]         lfsr;
  logic [9:0]          pl [NUM_PIPES];
  logic [9:0]          pr [NUM_PIPES];
  logic [9:0]          pg [NUM_PIPES];

  logic [8:0]          r9;
  logic [8:0]          r_wrap;
  logic [9:0]          new_gap;
  logic [10:0]         adv_r   [NUM_PIPES];
  logic                respawn [NUM_PIPES];
  logic [9:0]          nxt_l   [NUM_PIPES];
  logic                do_move;
  logic                restart;

  function automatic logic [9:0] init_l(input int unsigned i);
    return 10'(INIT_X + i * SPACING);
  endfunction

  assign refr_tick = &div;
  assign running   = (state == S_RUN);
  assign do_move   = (state == S_RUN) && refr_tick && !collide;
  assign restart   = (state == S_HALT) && start;

  // adv_r is the right edge after a normal move; at or left of MIN_X the pipe respawns
  always_comb begin
    r9      = {1'b0, lfsr[7:0]};
    r_wrap  = (r9 >= 9'(GAP_SPAN)) ? r9 - 9'(GAP_SPAN) : r9;
    new_gap = 10'(GAP_BASE) + {1'b0, r_wrap};
    for (int unsigned i = 0; i < NUM_PIPES; i++) begin
      adv_r[i]   = {1'b0, pl[i]} + 11'(PIPE_W) - 11'(SPEED);
      respawn[i] = (adv_r[i] <= 11'(MIN_X));
      nxt_l[i]   = respawn[i] ? 10'(MAX_X) : pl[i] - 10'(SPEED);
    end
  end

`ifdef PIPE_PASS_CNT_EN
  logic [8:0] pass_sum;
  logic [7:0] pass_next;

  always_comb begin
    pass_sum = {1'b0, pass_cnt};
    for (int unsigned i = 0; i < NUM_PIPES; i++) begin
      if (!respawn[i] && ({1'b0, pl[i]} + 11'(PIPE_W) > 11'(BIRD_X)) && (adv_r[i] <= 11'(BIRD_X)))
        pass_sum = pass_sum + 9'd1;
    end
    pass_next = pass_sum[8] ? 8'hFF : pass_sum[7:0];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      div   <= '0;
      lfsr  <= 16'hACE1;
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
        pl[i] <= init_l(i);
        pr[i] <= init_l(i) + 10'(PIPE_W);
        pg[i] <= 10'(INIT_GAP);
      end
`ifdef PIPE_PASS_CNT_EN
      pass_cnt <= '0;
`endif
    end else begin
      div  <= div + TICK_DIV'(1);
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        S_IDLE:  if (start)   state <= S_RUN;
        S_RUN:   if (collide) state <= S_HALT;
        S_HALT:  if (start)   state <= S_RUN;
        default: state <= S_IDLE;
      endcase
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
        if (restart) begin
          pl[i] <= init_l(i);
          pr[i] <= init_l(i) + 10'(PIPE_W);
          pg[i] <= 10'(INIT_GAP);
        end else if (do_move) begin
          pl[i] <= nxt_l[i];
          pr[i] <= nxt_l[i] + 10'(PIPE_W);
          if (respawn[i]) pg[i] <= new_gap;
        end
      end
`ifdef PIPE_PASS_CNT_EN
      if (restart)      pass_cnt <= '0;
      else if (do_move) pass_cnt <= pass_next;
`endif
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_out
    assign pipe_l[10*g +: 10]     = pl[g];
    assign pipe_r[10*g +: 10]     = pr[g];
    assign pipe_gap_t[10*g +: 10] = pg[g];
  end

endmodule
